msg_scheduler: RTL and testbench

Arbitrates report requests from the bot's navigation, sensing and pickup logic and serialises each granted report as an ASCII frame onto a byte-wide valid/ready link into the UART transmitter. Each requester gets one pending slot, so no event is lost while another frame is on the wire. After the end-of-run frame is sent, the block halts and accepts no further reports.

---
 rtl/msg_pkg.sv | 67 ++++++
 rtl/msg_if.sv | 9 +
 rtl/msg_char_rom.sv | 52 +++++
 rtl/msg_scheduler.sv | 132 +++++++++++++
 tb/tb_msg_scheduler.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/msg_pkg.sv
// rtl/msg_pkg.sv - shared ASCII constants, frame/state enums and argument-to-character helpers
package msg_pkg;

  localparam logic [7:0] CH_B    = 8'h42;
  localparam logic [7:0] CH_D    = 8'h44;
  localparam logic [7:0] CH_E    = 8'h45;
  localparam logic [7:0] CH_F    = 8'h46;
  localparam logic [7:0] CH_I    = 8'h49;
  localparam logic [7:0] CH_M    = 8'h4D;
  localparam logic [7:0] CH_N    = 8'h4E;
  localparam logic [7:0] CH_P    = 8'h50;
  localparam logic [7:0] CH_S    = 8'h53;
  localparam logic [7:0] CH_U    = 8'h55;
  localparam logic [7:0] CH_C    = 8'h43;
  localparam logic [7:0] CH_R    = 8'h52;
  localparam logic [7:0] CH_DASH = 8'h2D;
  localparam logic [7:0] CH_HASH = 8'h23;
  localparam logic [7:0] CH_QM   = 8'h3F;

  typedef enum logic [1:0] {
    FT_FAULT = 2'd0,
    FT_PICK  = 2'd1,
    FT_DEP   = 2'd2,
    FT_END   = 2'd3
  } frame_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEND = 3'd1,
    ST_GAP  = 3'd2,
    ST_DONE = 3'd3,
    ST_HALT = 3'd4
  } state_t;

  localparam logic [3:0] LEN_FAULT = 4'd10;
  localparam logic [3:0] LEN_PICK  = 4'd11;
  localparam logic [3:0] LEN_DEP   = 4'd13;
  localparam logic [3:0] LEN_END   = 4'd5;

  function automatic logic [3:0] frame_last(frame_t t);
    case (t)
      FT_FAULT: return LEN_FAULT - 4'd1;
      FT_PICK:  return LEN_PICK - 4'd1;
      FT_DEP:   return LEN_DEP - 4'd1;
      default:  return LEN_END - 4'd1;
    endcase
  endfunction

  function automatic logic [7:0] unit_char(logic [1:0] unit);
    case (unit)
      2'd1:    return CH_E;
      2'd2:    return CH_C;
      2'd3:    return CH_R;
      default: return CH_QM;
    endcase
  endfunction

  function automatic logic [7:0] su_char(logic [2:0] su);
    if (su >= 3'd1 && su <= 3'd4) return 8'h30 + {5'd0, su};
    return CH_QM;
  endfunction

  function automatic logic [7:0] loc_char(logic [1:0] loc);
    return 8'h31 + {6'd0, loc};
  endfunction

endpackage

// File: rtl/msg_if.sv
// rtl/msg_if.sv - byte-wide valid/ready link from the scheduler into the UART transmitter
interface msg_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;

  modport master (output tx_valid, output tx_data, input tx_ready);
  modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/msg_char_rom.sv
// rtl/msg_char_rom.sv - combinational lookup of the frame character at a given index
module msg_char_rom
  import msg_pkg::*;
(
  input  frame_t      ftype,
  input  logic [3:0]  index,
  input  logic [1:0]  unit,
  input  logic [2:0]  su,
  input  logic [1:0]  loc,
  output logic [7:0]  ch
);

  always_comb begin
    ch = CH_QM;
    case (ftype)
      FT_FAULT: case (index)
        4'd0: ch = CH_F;           4'd1: ch = CH_I;
        4'd2: ch = CH_M;           4'd3: ch = CH_DASH;
        4'd4: ch = unit_char(unit); 4'd5: ch = CH_S;
        4'd6: ch = CH_U;           4'd7: ch = su_char(su);
        4'd8: ch = CH_DASH;        4'd9: ch = CH_HASH;
        default: ch = CH_QM;
      endcase
      FT_PICK: case (index)
        4'd0: ch = CH_B;           4'd1: ch = CH_P;
        4'd2: ch = CH_M;           4'd3: ch = CH_DASH;
        4'd4: ch = CH_S;           4'd5: ch = CH_U;
        4'd6: ch = CH_DASH;        4'd7: ch = CH_B;
        4'd8: ch = loc_char(loc);  4'd9: ch = CH_DASH;
        4'd10: ch = CH_HASH;
        default: ch = CH_QM;
      endcase
      FT_DEP: case (index)
        4'd0: ch = CH_B;           4'd1: ch = CH_D;
        4'd2: ch = CH_M;           4'd3: ch = CH_DASH;
        4'd4: ch = unit_char(unit); 4'd5: ch = CH_S;
        4'd6: ch = CH_U;           4'd7: ch = su_char(su);
        4'd8: ch = CH_DASH;        4'd9: ch = CH_B;
        4'd10: ch = loc_char(loc); 4'd11: ch = CH_DASH;
        4'd12: ch = CH_HASH;
        default: ch = CH_QM;
      endcase
      default: case (index)
        4'd0: ch = CH_E;           4'd1: ch = CH_N;
        4'd2: ch = CH_D;           4'd3: ch = CH_DASH;
        4'd4: ch = CH_HASH;
        default: ch = CH_QM;
      endcase
    endcase
  end

endmodule

// File: rtl/msg_scheduler.sv
// rtl/msg_scheduler.sv - pending report slots, fixed-priority arbiter and frame serialiser FSM
module msg_scheduler
  import msg_pkg::*;
#(
  parameter int GAP_CYCLES = 0
) (
  input  logic       clk_50M,
  input  logic       reset,
  input  logic       fault_req,
  input  logic [1:0] fault_unit,
  input  logic [2:0] fault_su,
  input  logic       pick_req,
  input  logic [1:0] pick_loc,
  input  logic       dep_req,
  input  logic [1:0] dep_unit,
  input  logic [2:0] dep_su,
  input  logic [1:0] dep_loc,
  input  logic       end_req,
  msg_if.master      tx,
  output logic       busy,
  output logic       msg_done,
  output logic       halted,
  output logic       drop_err
);

  localparam logic [15:0] GAP_LAST = 16'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t     state, state_d;
  logic       fault_pend, pick_pend, dep_pend, end_pend;
  logic [1:0] fault_unit_q, pick_loc_q, dep_unit_q, dep_loc_q;
  logic [2:0] fault_su_q, dep_su_q;
  frame_t     cur_type;
  logic [1:0] cur_unit, cur_loc;
  logic [2:0] cur_su;
  logic [3:0] index;
  logic [15:0] gap_cnt;
  logic       grant_fault, grant_dep, grant_pick, grant_end;
  logic       hs, last_byte;
  logic [7:0] ch;

  msg_char_rom u_rom (
    .ftype (cur_type),
    .index (index),
    .unit  (cur_unit),
    .su    (cur_su),
    .loc   (cur_loc),
    .ch    (ch)
  );

  always_comb begin
    state_d     = state;
    grant_fault = 1'b0;
    grant_dep   = 1'b0;
    grant_pick  = 1'b0;
    grant_end   = 1'b0;
    hs          = (state == ST_SEND) && tx.tx_ready;
    last_byte   = (index == frame_last(cur_type));
    case (state)
      ST_IDLE: begin
        if (fault_pend)     grant_fault = 1'b1;
        else if (dep_pend)  grant_dep   = 1'b1;
        else if (pick_pend) grant_pick  = 1'b1;
        else if (end_pend)  grant_end   = 1'b1;
        if (fault_pend || dep_pend || pick_pend || end_pend) state_d = ST_SEND;
      end
      ST_SEND: if (hs) state_d = last_byte ? ST_DONE : ((GAP_CYCLES > 0) ? ST_GAP : ST_SEND);
      ST_GAP:  if (gap_cnt == GAP_LAST) state_d = ST_SEND;
      ST_DONE: state_d = (cur_type == FT_END) ? ST_HALT : ST_IDLE;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  // A request landing on its own grant cycle refills the slot; only a still-pending slot counts as a drop.
  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      fault_pend <= 1'b0; pick_pend <= 1'b0; dep_pend <= 1'b0; end_pend <= 1'b0;
      fault_unit_q <= '0; fault_su_q <= '0; pick_loc_q <= '0;
      dep_unit_q <= '0; dep_su_q <= '0; dep_loc_q <= '0;
      drop_err <= 1'b0;
    end else if (state != ST_HALT) begin
      if (fault_req) begin
        fault_pend <= 1'b1; fault_unit_q <= fault_unit; fault_su_q <= fault_su;
        if (fault_pend && !grant_fault) drop_err <= 1'b1;
      end else if (grant_fault) fault_pend <= 1'b0;
      if (pick_req) begin
        pick_pend <= 1'b1; pick_loc_q <= pick_loc;
        if (pick_pend && !grant_pick) drop_err <= 1'b1;
      end else if (grant_pick) pick_pend <= 1'b0;
      if (dep_req) begin
        dep_pend <= 1'b1; dep_unit_q <= dep_unit; dep_su_q <= dep_su; dep_loc_q <= dep_loc;
        if (dep_pend && !grant_dep) drop_err <= 1'b1;
      end else if (grant_dep) dep_pend <= 1'b0;
      if (end_req) begin
        end_pend <= 1'b1;
        if (end_pend && !grant_end) drop_err <= 1'b1;
      end else if (grant_end) end_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cur_type <= FT_FAULT; cur_unit <= '0; cur_su <= '0; cur_loc <= '0;
      index <= '0;
      gap_cnt <= '0;
    end else begin
      state <= state_d;
      if (grant_fault) begin
        cur_type <= FT_FAULT; cur_unit <= fault_unit_q; cur_su <= fault_su_q; index <= '0;
      end else if (grant_dep) begin
        cur_type <= FT_DEP; cur_unit <= dep_unit_q; cur_su <= dep_su_q; cur_loc <= dep_loc_q;
        index <= '0;
      end else if (grant_pick) begin
        cur_type <= FT_PICK; cur_loc <= pick_loc_q; index <= '0;
      end else if (grant_end) begin
        cur_type <= FT_END; index <= '0;
      end else if (hs && !last_byte) begin
        index <= index + 4'd1;
      end
      if (state == ST_GAP) gap_cnt <= gap_cnt + 16'd1;
      else                 gap_cnt <= '0;
    end
  end

  assign tx.tx_valid = (state == ST_SEND);
  assign tx.tx_data  = (state == ST_SEND) ? ch : 8'h00;
  assign busy        = (state == ST_SEND) || (state == ST_GAP) || (state == ST_DONE);
  assign msg_done    = (state == ST_DONE);
  assign halted      = (state == ST_HALT);

endmodule

// File: tb/tb_msg_scheduler.sv
// tb/tb_msg_scheduler.sv - directed bench with a frame-string model and per-cycle link checker
module tb_msg_scheduler;

  logic       clk_50M = 1'b0;
  logic       reset = 1'b1;
  logic       fault_req = 1'b0, pick_req = 1'b0, dep_req = 1'b0, end_req = 1'b0;
  logic [1:0] fault_unit = '0, pick_loc = '0, dep_unit = '0, dep_loc = '0;
  logic [2:0] fault_su = '0, dep_su = '0;
  logic       busy, msg_done, halted, drop_err;
  logic       rand_rdy = 1'b0;

  int checks = 0;
  int errors = 0;
  int hs_count = 0;
  logic [7:0] exp_q[$];

  msg_if lnk ();

  msg_scheduler #(.GAP_CYCLES(0)) dut (
    .clk_50M    (clk_50M),
    .reset      (reset),
    .fault_req  (fault_req),
    .fault_unit (fault_unit),
    .fault_su   (fault_su),
    .pick_req   (pick_req),
    .pick_loc   (pick_loc),
    .dep_req    (dep_req),
    .dep_unit   (dep_unit),
    .dep_su     (dep_su),
    .dep_loc    (dep_loc),
    .end_req    (end_req),
    .tx         (lnk),
    .busy       (busy),
    .msg_done   (msg_done),
    .halted     (halted),
    .drop_err   (drop_err)
  );

  always #5 clk_50M = ~clk_50M;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_str(string name, string act, string exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%s required=%s", name, act, exp);
    end
  endtask

  // Frame text built straight from the report format rules.
  function automatic string uc(int u);
    case (u)
      1: return "E";
      2: return "C";
      3: return "R";
      default: return "?";
    endcase
  endfunction

  function automatic string sc(int su);
    if (su >= 1 && su <= 4) return $sformatf("%0d", su);
    return "?";
  endfunction

  function automatic string lc(int loc);
    return $sformatf("B%0d", loc + 1);
  endfunction

  function automatic string fault_frame(int u, int su);
    return {"FIM-", uc(u), "SU", sc(su), "-#"};
  endfunction

  function automatic string pick_frame(int loc);
    return {"BPM-SU-", lc(loc), "-#"};
  endfunction

  function automatic string dep_frame(int u, int su, int loc);
    return {"BDM-", uc(u), "SU", sc(su), "-", lc(loc), "-#"};
  endfunction

  task automatic push_frame(string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  task automatic tick();
    @(posedge clk_50M);
    #1;
    if (rand_rdy) lnk.tx_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_drain(string name, int budget);
    logic done;
    done = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk_50M);
      if (exp_q.size() == 0 && !busy) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    chk(name, done, 1'b1);
  endtask

  logic       prev_stall = 1'b0;
  logic       prev_hash = 1'b0;
  logic [7:0] prev_data = '0;

  always @(negedge clk_50M) begin
    if (reset) begin
      prev_stall = 1'b0;
      prev_hash  = 1'b0;
    end else begin
      chk("msg_done", msg_done, prev_hash);
      if (prev_stall) begin
        chk("stall_valid", lnk.tx_valid, 1'b1);
        chk("stall_data", lnk.tx_data, prev_data);
      end
      if (lnk.tx_valid && lnk.tx_ready) begin
        hs_count++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte actual=%02h required=none", lnk.tx_data);
        end else begin
          chk("tx_data", lnk.tx_data, exp_q.pop_front());
        end
      end
      prev_hash  = lnk.tx_valid && lnk.tx_ready && (lnk.tx_data == 8'h23);
      prev_stall = lnk.tx_valid && !lnk.tx_ready;
      prev_data  = lnk.tx_data;
    end
  end

  initial begin
    int base;
    lnk.tx_ready = 1'b0;
    repeat (3) tick();
    @(negedge clk_50M);
    chk("rst_valid", lnk.tx_valid, 1'b0);
    chk("rst_data", lnk.tx_data, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", msg_done, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_drop", drop_err, 1'b0);
    tick();
    reset = 1'b0;

    chk_str("model_fault", fault_frame(2, 3), "FIM-CSU3-#");
    chk_str("model_dep", dep_frame(3, 4, 3), "BDM-RSU4-B4-#");
    chk_str("model_pick", pick_frame(0), "BPM-SU-B1-#");
    chk_str("model_badarg", fault_frame(0, 7), "FIM-?SU?-#");

    // single fault with 2-cycle latency
    lnk.tx_ready = 1'b1;
    tick();
    fault_req = 1'b1; fault_unit = 2'd2; fault_su = 3'd3;
    push_frame(fault_frame(2, 3));
    tick();
    fault_req = 1'b0;
    @(negedge clk_50M);
    chk("lat_cycle1_valid", lnk.tx_valid, 1'b0);
    tick();
    @(negedge clk_50M);
    chk("lat_cycle2_valid", lnk.tx_valid, 1'b1);
    chk("lat_cycle2_busy", busy, 1'b1);
    wait_drain("drain_fault", 100);
    chk("t1_drop", drop_err, 1'b0);

    // simultaneous fault and pick: fault wins
    tick();
    pick_req = 1'b1; pick_loc = 2'd0;
    fault_req = 1'b1; fault_unit = 2'd1; fault_su = 3'd1;
    push_frame(fault_frame(1, 1));
    push_frame(pick_frame(0));
    tick();
    pick_req = 1'b0; fault_req = 1'b0;
    wait_drain("drain_simul", 100);
    chk("t2_drop", drop_err, 1'b0);

    // backpressure on a DEP frame
    rand_rdy = 1'b1;
    tick();
    dep_req = 1'b1; dep_unit = 2'd3; dep_su = 3'd4; dep_loc = 2'd3;
    push_frame(dep_frame(3, 4, 3));
    tick();
    dep_req = 1'b0;
    wait_drain("drain_backpressure", 400);
    rand_rdy = 1'b0;
    lnk.tx_ready = 1'b1;

    // pick slot overwritten while a fault frame is in flight
    tick();
    fault_req = 1'b1; fault_unit = 2'd1; fault_su = 3'd2;
    push_frame(fault_frame(1, 2));
    tick();
    fault_req = 1'b0;
    tick();
    tick();
    pick_req = 1'b1; pick_loc = 2'd1;
    tick();
    pick_req = 1'b0;
    tick();
    pick_req = 1'b1; pick_loc = 2'd2;
    tick();
    pick_req = 1'b0;
    push_frame(pick_frame(2));
    wait_drain("drain_overwrite", 100);
    chk("t4_drop", drop_err, 1'b1);

    tick();
    reset = 1'b1;
    tick();
    @(negedge clk_50M);
    chk("reset_clears_drop", drop_err, 1'b0);
    tick();
    reset = 1'b0;

    // END frame then halt; later requests ignored
    tick();
    end_req = 1'b1;
    push_frame("END-#");
    tick();
    end_req = 1'b0;
    tick();
    pick_req = 1'b1; pick_loc = 2'd0;
    tick();
    pick_req = 1'b0;
    wait_drain("drain_end", 100);
    chk("end_halted", halted, 1'b1);
    tick();
    fault_req = 1'b1; fault_unit = 2'd1; fault_su = 3'd1;
    tick();
    fault_req = 1'b0;
    repeat (20) tick();
    @(negedge clk_50M);
    chk("halt_stays", halted, 1'b1);
    chk("halt_busy", busy, 1'b0);
    chk("halt_no_drop", drop_err, 1'b0);

    tick();
    reset = 1'b1;
    tick();
    @(negedge clk_50M);
    chk("reset_leaves_halt", halted, 1'b0);
    tick();
    reset = 1'b0;

    // reset after four bytes of a DEP frame, with a pick pending
    tick();
    base = hs_count;
    dep_req = 1'b1; dep_unit = 2'd2; dep_su = 3'd2; dep_loc = 2'd1;
    push_frame(dep_frame(2, 2, 1));
    tick();
    dep_req = 1'b0;
    tick();
    pick_req = 1'b1; pick_loc = 2'd3;
    tick();
    pick_req = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk_50M);
      #1;
      if (hs_count - base >= 4) break;
    end
    chk("midframe_hs4", hs_count - base, 4);
    @(posedge clk_50M);
    #1;
    chk("midframe_valid_pre", lnk.tx_valid, 1'b1);
    reset = 1'b1;
    #1;
    chk("midframe_valid_rst", lnk.tx_valid, 1'b0);
    chk("midframe_busy_rst", busy, 1'b0);
    exp_q.delete();
    tick();
    tick();
    reset = 1'b0;
    repeat (10) tick();
    @(negedge clk_50M);
    chk("slots_empty_busy", busy, 1'b0);
    chk("slots_empty_valid", lnk.tx_valid, 1'b0);

    // invalid arguments
    tick();
    fault_req = 1'b1; fault_unit = 2'd0; fault_su = 3'd7;
    push_frame(fault_frame(0, 7));
    tick();
    fault_req = 1'b0;
    wait_drain("drain_badarg", 100);
    chk("final_drop", drop_err, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
